// File: rtl/blackjack_pkg.sv
// Shared card codes, deck geometry, dealer state encoding and LFSR helpers
// for the blackjack card dealer.
package blackjack_pkg;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_ACE  = 4'd10;
  localparam logic [3:0] CARD_TEN  = 4'd11;

  localparam int DECK_SIZE = 52;
  localparam int SUIT_SIZE = 13;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SHUFFLE,
    READY,
    EMPTY
  } dealer_state_t;

  // Position within a suit: 0 is the ace, 1..8 are pips 2..9, 9..12 count as ten.
  function automatic logic [3:0] rank_code(input logic [3:0] k);
    if (k == 4'd0)      return CARD_ACE;
    else if (k <= 4'd8) return k + 4'd1;
    else                return CARD_TEN;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR (taps 16'hB400) that feeds the shuffle
// index; a zero SEED is replaced by the default seed so it never locks up.
module card_lfsr
  import blackjack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] lfsr
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= INIT;
    else        lfsr <= lfsr_next(lfsr);
  end

endmodule

// File: rtl/card_dealer.sv
// 52-card blackjack dealer: fills a deck, Fisher-Yates shuffles it from an LFSR
// and deals one card per request. DEALER_AUTO_RESHUFFLE_EN refills on exhaustion.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       shuffle_req,
  input  logic       deal_req,
  output logic [3:0] card,
  output logic       card_valid,
  output logic       busy,
  output logic       deck_empty,
  output logic [5:0] cards_left
);

  localparam logic [5:0] LAST_IDX   = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL_COUNT = 6'(DECK_SIZE);
  localparam logic [3:0] LAST_RANK  = 4'(SUIT_SIZE - 1);

  function automatic logic [5:0] sat_dec(input logic [5:0] v);
    return (v == 6'd0) ? 6'd0 : v - 6'd1;
  endfunction

  dealer_state_t state;
  logic [15:0]   lfsr;
  logic [5:0]    pick;
  logic [5:0]    idx;
  logic [3:0]    rank;
  logic [5:0]    top;
  logic [3:0]    deck [DECK_SIZE];
  logic          go_shuffle;
  logic          fill_we;
  logic          swap_en;
  logic          unused_lfsr_hi;

  card_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign pick           = lfsr[5:0];
  assign unused_lfsr_hi = ^lfsr[15:6];

  always_comb begin
    go_shuffle = 1'b0;
    fill_we    = 1'b0;
    swap_en    = 1'b0;
    if (shuffle_req && (state == IDLE || state == READY || state == EMPTY))
      go_shuffle = 1'b1;
    if (state == FILL)
      fill_we = 1'b1;
    if (state == SHUFFLE && pick <= idx)
      swap_en = 1'b1;
  end

  // Deck storage carries no reset; it is fully rewritten by FILL before use.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      deck[idx] <= rank_code(rank);
    end else if (swap_en) begin
      deck[idx]  <= deck[pick];
      deck[pick] <= deck[idx];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      card       <= CARD_NONE;
      card_valid <= 1'b0;
      busy       <= 1'b0;
      deck_empty <= 1'b1;
      cards_left <= 6'd0;
      top        <= 6'd0;
      idx        <= 6'd0;
      rank       <= 4'd0;
    end else begin
      card       <= CARD_NONE;
      card_valid <= 1'b0;
      if (go_shuffle) begin
        state      <= FILL;
        busy       <= 1'b1;
        deck_empty <= 1'b1;
        cards_left <= 6'd0;
        top        <= 6'd0;
        idx        <= 6'd0;
        rank       <= 4'd0;
      end else begin
        case (state)
          FILL: begin
`ifdef DEALER_AUTO_RESHUFFLE_EN
            deck_empty <= 1'b0;
`endif
            rank <= (rank == LAST_RANK) ? 4'd0 : rank + 4'd1;
            if (idx == LAST_IDX) begin
              state <= SHUFFLE;
            end else begin
              idx <= idx + 6'd1;
            end
          end
          SHUFFLE: begin
            // Out-of-range picks simply retry on the next LFSR value.
            if (swap_en) begin
              if (idx == 6'd1) begin
                state      <= READY;
                busy       <= 1'b0;
                top        <= 6'd0;
                cards_left <= FULL_COUNT;
                deck_empty <= 1'b0;
              end else begin
                idx <= idx - 6'd1;
              end
            end
          end
          READY: begin
            if (deal_req) begin
              card       <= deck[top];
              card_valid <= 1'b1;
              top        <= top + 6'd1;
              cards_left <= sat_dec(cards_left);
              if (top == LAST_IDX) begin
                deck_empty <= 1'b1;
`ifdef DEALER_AUTO_RESHUFFLE_EN
                state <= FILL;
                busy  <= 1'b1;
                idx   <= 6'd0;
                rank  <= 4'd0;
`else
                state <= EMPTY;
`endif
              end
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: table-driven control checks plus a
// card scoreboard fed by an independent shuffle model.
module tb_card_dealer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clock;
  logic       reset;
  logic       shuffle_req;
  logic       deal_req;
  logic [3:0] card;
  logic       card_valid;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;

  card_dealer #(
    .SEED (SEED)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .shuffle_req (shuffle_req),
    .deal_req    (deal_req),
    .card        (card),
    .card_valid  (card_valid),
    .busy        (busy),
    .deck_empty  (deck_empty),
    .cards_left  (cards_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         shuf;
    bit         deal;
    bit         valid;
    bit         bsy;
    bit         empty;
    logic [5:0] left;
  } vec_t;

  vec_t        vt [8];
  int          checks;
  int          failures;
  logic [3:0]  sb [$];
  logic [3:0]  exp_deck [52];
  int          hist [16];
  int          m_top;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] adv(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic logic [3:0] tb_code(input int k);
    if (k == 0) return 4'd10;
    if (k <= 8) return 4'(k + 1);
    return 4'd11;
  endfunction

  // Reference LFSR running from the same reset.
  always @(posedge clock or negedge reset) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= adv(m_lfsr);
  end

  // Expected deck for a shuffle accepted with LFSR value l0; returns the
  // number of shuffle cycles (52 fill cycles precede the first pick).
  function automatic int build_expected(input logic [15:0] l0);
    logic [15:0] x;
    logic [3:0]  t;
    int          i;
    int          j;
    int          att;
    x = l0;
    for (int n = 0; n < 53; n++) x = adv(x);
    for (int n = 0; n < 52; n++) exp_deck[n] = tb_code(n % 13);
    i = 51;
    att = 0;
    while (i >= 1 && att < 20000) begin
      j = int'(x[5:0]);
      att++;
      if (j <= i) begin
        t = exp_deck[i];
        exp_deck[i] = exp_deck[j];
        exp_deck[j] = t;
        i--;
      end
      x = adv(x);
    end
    return att;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (card_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_card_valid", 1, 0);
      end else begin
        check("card_value", int'(card), int'(sb.pop_front()));
        hist[card] = hist[card] + 1;
      end
    end
  end

  task automatic apply_row(input int r, input bit ready);
    shuffle_req = vt[r].shuf;
    deal_req    = vt[r].deal;
    if (vt[r].deal && ready) begin
      sb.push_back(exp_deck[m_top]);
      m_top++;
    end
    @(negedge clock);
    shuffle_req = 1'b0;
    deal_req    = 1'b0;
    check($sformatf("row%0d_valid", r), int'(card_valid), int'(vt[r].valid));
    check($sformatf("row%0d_busy", r), int'(busy), int'(vt[r].bsy));
    check($sformatf("row%0d_empty", r), int'(deck_empty), int'(vt[r].empty));
    check($sformatf("row%0d_left", r), int'(cards_left), int'(vt[r].left));
    if (!vt[r].valid) check($sformatf("row%0d_card_zero", r), int'(card), 0);
  endtask

  task automatic do_shuffle(input bit with_deal);
    int att;
    int cnt;
    att = build_expected(m_lfsr);
    shuffle_req = 1'b1;
    deal_req    = with_deal;
    @(negedge clock);
    shuffle_req = 1'b0;
    deal_req    = 1'b0;
    if (with_deal) begin
      check("collision_no_valid", int'(card_valid), 0);
      check("collision_busy", int'(busy), 1);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      cnt++;
      @(negedge clock);
    end
    check("busy_cycles", cnt, 52 + att);
    check("busy_at_least_103", int'(cnt >= 103), 1);
    check("ready_cards_left", int'(cards_left), 52);
    check("ready_deck_empty", int'(deck_empty), 0);
    m_top = 0;
  endtask

  task automatic deal_n(input int n);
    for (int k = 0; k < n; k++) begin
      deal_req = 1'b1;
      sb.push_back(exp_deck[m_top]);
      m_top++;
      @(negedge clock);
    end
    deal_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_top = 0;
    for (int k = 0; k < 16; k++) hist[k] = 0;
    vt[0] = '{0, 1, 0, 0, 1, 6'd0};
    vt[1] = '{0, 0, 0, 0, 1, 6'd0};
    vt[2] = '{0, 1, 0, 0, 1, 6'd0};
    vt[3] = '{0, 1, 1, 0, 0, 6'd51};
    vt[4] = '{0, 0, 0, 0, 0, 6'd51};
    vt[5] = '{0, 1, 1, 0, 0, 6'd50};
    vt[6] = '{0, 1, 1, 0, 0, 6'd49};
    vt[7] = '{0, 0, 0, 0, 0, 6'd49};

    reset = 1'b0;
    shuffle_req = 1'b0;
    deal_req = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_card", int'(card), 0);
    check("rst_valid", int'(card_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_empty", int'(deck_empty), 1);
    check("rst_left", int'(cards_left), 0);
    reset = 1'b1;
    @(negedge clock);

    for (int r = 0; r < 3; r++) apply_row(r, 1'b0);

    do_shuffle(1'b0);
    for (int r = 3; r < 8; r++) apply_row(r, 1'b1);

    deal_n(49);
    check("last_deal_valid", int'(card_valid), 1);
    check("last_deal_empty", int'(deck_empty), 1);
    check("last_deal_left", int'(cards_left), 0);
    deal_req = 1'b1;
    @(negedge clock);
    deal_req = 1'b0;
    check("extra_deal_valid", int'(card_valid), 0);
    check("extra_deal_empty", int'(deck_empty), 1);
    check("extra_deal_left", int'(cards_left), 0);
    @(negedge clock);
    for (int c = 2; c <= 10; c++) check($sformatf("hist_code%0d", c), hist[c], 4);
    check("hist_code11", hist[11], 16);
    check("sb_drained_first_deck", sb.size(), 0);

    shuffle_req = 1'b1;
    @(negedge clock);
    shuffle_req = 1'b0;
    repeat (60) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_empty", int'(deck_empty), 1);
    check("midrst_left", int'(cards_left), 0);
    check("midrst_valid", int'(card_valid), 0);
    check("midrst_card", int'(card), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    do_shuffle(1'b0);
    deal_n(2);
    @(negedge clock);
    do_shuffle(1'b1);
    deal_n(3);
    check("post_collision_left", int'(cards_left), 49);
    repeat (2) @(negedge clock);
    check("sb_drained_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
